// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store to single-beat bus master with flush and stall handling.
// Define MEM_BUS_TIMEOUT_EN to include the acknowledge timeout watchdog.
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    input  logic        mem_stall_i,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic [31:0] rdata_o,
    output logic        stallreq_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state, state_next;
    logic   flushed;
    logic   start;
    logic   finish;
    logic   discard;
    logic   timed_out;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_bus_ctrl: TIMEOUT must be in 2..255");
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    logic [7:0] tmo_cnt;

    // Fires on the last allowed BUSY cycle so the bus drops after exactly TIMEOUT cycles;
    // an ack in that same cycle still wins.
    assign timed_out = (state == BUSY) && !bus_ack_i && ((tmo_cnt + 8'd1) >= TMO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
            err_o   <= 1'b0;
        end else begin
            err_o <= timed_out;
            if (start) begin
                tmo_cnt <= 8'd0;
            end else if (state == BUSY && !bus_ack_i && tmo_cnt < TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stallreq_o = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        discard    = flushed || flush_i;
        case (state)
            IDLE: begin
                if (req_i && !flush_i) begin
                    start      = 1'b1;
                    stallreq_o = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stallreq_o = 1'b1;
                if (bus_ack_i || timed_out) begin
                    finish     = 1'b1;
                    state_next = discard ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (flush_i || !mem_stall_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            stallreq_o = 1'b0;
        end
    end

    // A flushed access still runs to its ack; only the returned data is thrown away.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0000_0000;
            bus_sel_o   <= 4'b0000;
            bus_wdata_o <= 32'h0000_0000;
            rdata_o     <= 32'h0000_0000;
            flushed     <= 1'b0;
        end else if (start) begin
            bus_cyc_o   <= 1'b1;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= we_i;
            bus_addr_o  <= addr_i;
            bus_sel_o   <= sel_i;
            bus_wdata_o <= wdata_i;
            flushed     <= 1'b0;
        end else if (state == BUSY) begin
            if (flush_i) begin
                flushed <= 1'b1;
            end
            if (finish) begin
                bus_cyc_o <= 1'b0;
                bus_stb_o <= 1'b0;
                bus_we_o  <= 1'b0;
                flushed   <= 1'b0;
                if (timed_out) begin
                    rdata_o <= 32'h0000_0000;
                end else if (!discard) begin
                    rdata_o <= bus_we_o ? 32'h0000_0000 : bus_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; TIMEOUT is set to 4 so the
// watchdog scenario stays short when MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        mem_stall_i;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] rdata_o;
    logic        stallreq_o;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    mem_bus_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .wdata_i     (wdata_i),
        .flush_i     (flush_i),
        .mem_stall_i (mem_stall_i),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_cyc_o   (bus_cyc_o),
        .bus_stb_o   (bus_stb_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .rdata_o     (rdata_o),
        .stallreq_o  (stallreq_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req_i       = 1'b0;
        we_i        = 1'b0;
        addr_i      = 32'h0;
        sel_i       = 4'h0;
        wdata_i     = 32'h0;
        flush_i     = 1'b0;
        mem_stall_i = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'hDEAD_BEEF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req_i = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, err_o, stallreq_o} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 00000",
                     {bus_cyc_o, bus_stb_o, bus_we_o, err_o, stallreq_o});
        end
        vectors++;
        if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || rdata_o !== 32'h0 || bus_sel_o !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got addr %h wdata %h rdata %h sel %h, expected all zero",
                     bus_addr_o, bus_wdata_o, rdata_o, bus_sel_o);
        end
        rst   = 1'b0;
        req_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        int cyc_cnt   = 0;
        we_i   = 1'b0;
        addr_i = 32'h0000_0010;
        sel_i  = 4'hF;
        for (int c = 0; c < 6; c++) begin
            req_i       = (c <= 3);
            bus_ack_i   = (c == 3);
            bus_rdata_i = (c == 3) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            #1;
            if (stallreq_o === 1'b1) stall_cnt++;
            if (bus_cyc_o === 1'b1 && bus_stb_o === 1'b1) cyc_cnt++;
            if (c == 2) begin
                vectors++;
                if (bus_addr_o !== 32'h10 || bus_sel_o !== 4'hF || bus_we_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL load_bus: got addr %h sel %h we %b, expected 00000010 f 0",
                             bus_addr_o, bus_sel_o, bus_we_o);
                end
            end
            if (c == 4) begin
                vectors++;
                if (rdata_o !== 32'h1234_5678 || bus_cyc_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL load_hold: got rdata %h cyc %b, expected 12345678 0",
                             rdata_o, bus_cyc_o);
                end
            end
            next_cycle();
        end
        vectors++;
        if (stall_cnt !== 4 || cyc_cnt !== 3) begin
            miscompares++;
            $display("[TB] FAIL load_latency: got stall %0d cyc %0d, expected 4 3", stall_cnt, cyc_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_store();
        int stall_cnt = 0;
        int we_cnt    = 0;
        we_i    = 1'b1;
        addr_i  = 32'h0000_0020;
        sel_i   = 4'b0011;
        wdata_i = 32'hCAFE_BABE;
        for (int c = 0; c < 4; c++) begin
            req_i     = (c <= 1);
            bus_ack_i = (c == 1);
            #1;
            if (stallreq_o === 1'b1) stall_cnt++;
            if (bus_we_o === 1'b1) we_cnt++;
            if (c == 1) begin
                vectors++;
                if (bus_sel_o !== 4'b0011 || bus_wdata_o !== 32'hCAFE_BABE || bus_addr_o !== 32'h20) begin
                    miscompares++;
                    $display("[TB] FAIL store_bus: got sel %b wdata %h addr %h, expected 0011 cafebabe 00000020",
                             bus_sel_o, bus_wdata_o, bus_addr_o);
                end
            end
            if (c == 2) begin
                vectors++;
                if (rdata_o !== 32'h0) begin
                    miscompares++;
                    $display("[TB] FAIL store_rdata: got %h, expected 00000000", rdata_o);
                end
            end
            next_cycle();
        end
        vectors++;
        if (stall_cnt !== 2 || we_cnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL store_latency: got stall %0d we %0d, expected 2 1", stall_cnt, we_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        we_i   = 1'b0;
        addr_i = 32'h0000_0030;
        sel_i  = 4'hF;
        for (int c = 0; c < 7; c++) begin
            req_i       = 1'b1;
            mem_stall_i = (c >= 2 && c <= 4);
            bus_ack_i   = (c >= 1 && c <= 5);
            bus_rdata_i = (c == 1) ? 32'hA5A5_0001 : 32'h5555_5555;
            #1;
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (stallreq_o !== 1'b0 || rdata_o !== 32'hA5A5_0001) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold c%0d: got stall %b rdata %h, expected 0 a5a50001",
                             c, stallreq_o, rdata_o);
                end
            end
            if (c == 6) begin
                vectors++;
                if (stallreq_o !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL stall_release: got stall %b, expected 1", stallreq_o);
                end
                idle_inputs();
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_busy();
        we_i   = 1'b0;
        addr_i = 32'h0000_0040;
        sel_i  = 4'hF;
        for (int c = 0; c < 5; c++) begin
            req_i       = (c <= 3);
            flush_i     = (c == 1);
            bus_ack_i   = (c == 3);
            bus_rdata_i = (c == 3) ? 32'hFFFF_0000 : 32'hDEAD_BEEF;
            #1;
            if (c >= 1 && c <= 3) begin
                vectors++;
                if (bus_cyc_o !== 1'b1 || bus_stb_o !== 1'b1 || stallreq_o !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL flush_busy c%0d: got cyc %b stb %b stall %b, expected 1 1 1",
                             c, bus_cyc_o, bus_stb_o, stallreq_o);
                end
            end
            if (c == 4) begin
                vectors++;
                if (stallreq_o !== 1'b0 || bus_cyc_o !== 1'b0 || rdata_o !== 32'hA5A5_0001) begin
                    miscompares++;
                    $display("[TB] FAIL flush_done: got stall %b cyc %b rdata %h, expected 0 0 a5a50001",
                             stallreq_o, bus_cyc_o, rdata_o);
                end
                req_i = 1'b1;
                #1;
                vectors++;
                if (stallreq_o !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL flush_no_hold: got stall %b, expected 1", stallreq_o);
                end
                idle_inputs();
            end
            next_cycle();
        end
    endtask

    task automatic test_idle_flush();
        req_i   = 1'b1;
        flush_i = 1'b1;
        addr_i  = 32'h0000_0050;
        #1;
        vectors++;
        if (stallreq_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_flush_stall: got %b, expected 0", stallreq_o);
        end
        next_cycle();
        idle_inputs();
        #1;
        vectors++;
        if (bus_cyc_o !== 1'b0 || bus_stb_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_flush_bus: got cyc %b stb %b, expected 0 0", bus_cyc_o, bus_stb_o);
        end
        next_cycle();
    endtask

    task automatic test_hold_flush();
        we_i   = 1'b0;
        addr_i = 32'h0000_0060;
        sel_i  = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req_i       = (c <= 1) || (c == 3);
            mem_stall_i = (c >= 2);
            flush_i     = (c == 2);
            bus_ack_i   = (c == 1);
            bus_rdata_i = (c == 1) ? 32'h0BAD_F00D : 32'hDEAD_BEEF;
            #1;
            if (c == 2) begin
                vectors++;
                if (rdata_o !== 32'h0BAD_F00D) begin
                    miscompares++;
                    $display("[TB] FAIL hold_flush_rdata: got %h, expected 0badf00d", rdata_o);
                end
            end
            if (c == 3) begin
                vectors++;
                if (stallreq_o !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL hold_flush_idle: got stall %b, expected 1", stallreq_o);
                end
                idle_inputs();
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        we_i   = 1'b0;
        addr_i = 32'h0000_0070;
        sel_i  = 4'hF;
`ifdef MEM_BUS_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            req_i = (c == 0);
            #1;
            if (c >= 1 && c <= 4) begin
                vectors++;
                if (bus_cyc_o !== 1'b1 || bus_stb_o !== 1'b1 || err_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL tmo_wait c%0d: got cyc %b stb %b err %b, expected 1 1 0",
                             c, bus_cyc_o, bus_stb_o, err_o);
                end
            end
            if (c == 5) begin
                vectors++;
                if (bus_cyc_o !== 1'b0 || err_o !== 1'b1 || rdata_o !== 32'h0 || stallreq_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL tmo_fire: got cyc %b err %b rdata %h stall %b, expected 0 1 00000000 0",
                             bus_cyc_o, err_o, rdata_o, stallreq_o);
                end
            end
            if (c == 6) begin
                vectors++;
                if (err_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL tmo_pulse: got err %b, expected 0", err_o);
                end
            end
            next_cycle();
        end
        for (int c = 0; c < 6; c++) begin
            req_i       = (c == 0);
            bus_ack_i   = (c == 4);
            bus_rdata_i = (c == 4) ? 32'h1357_9BDF : 32'hDEAD_BEEF;
            #1;
            if (c == 5) begin
                vectors++;
                if (err_o !== 1'b0 || rdata_o !== 32'h1357_9BDF || bus_cyc_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL tmo_ack_wins: got err %b rdata %h cyc %b, expected 0 13579bdf 0",
                             err_o, rdata_o, bus_cyc_o);
                end
            end
            next_cycle();
        end
`else
        begin
            int err_cnt = 0;
            for (int c = 0; c < 15; c++) begin
                req_i       = (c == 0);
                bus_ack_i   = (c == 12);
                bus_rdata_i = (c == 12) ? 32'h2468_ACE0 : 32'hDEAD_BEEF;
                #1;
                if (err_o !== 1'b0) err_cnt++;
                if (c == 11) begin
                    vectors++;
                    if (bus_cyc_o !== 1'b1 || stallreq_o !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL no_tmo_wait: got cyc %b stall %b, expected 1 1", bus_cyc_o, stallreq_o);
                    end
                end
                if (c == 13) begin
                    vectors++;
                    if (rdata_o !== 32'h2468_ACE0 || bus_cyc_o !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL no_tmo_done: got rdata %h cyc %b, expected 2468ace0 0", rdata_o, bus_cyc_o);
                    end
                end
                next_cycle();
            end
            vectors++;
            if (err_cnt !== 0) begin
                miscompares++;
                $display("[TB] FAIL no_tmo_err: got %0d err cycles, expected 0", err_cnt);
            end
        end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        we_i    = 1'b1;
        addr_i  = 32'h0000_0080;
        sel_i   = 4'hF;
        wdata_i = 32'h1111_2222;
        for (int c = 0; c < 6; c++) begin
            req_i       = (c == 0) || (c == 5);
            rst         = (c == 2);
            bus_ack_i   = (c == 3 || c == 4);
            bus_rdata_i = 32'h7777_7777;
            #1;
            if (c == 2) begin
                vectors++;
                if (stallreq_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rst_stall: got %b, expected 0", stallreq_o);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({bus_cyc_o, bus_stb_o, bus_we_o, err_o} !== 4'b0000 || bus_addr_o !== 32'h0 ||
                    bus_wdata_o !== 32'h0 || rdata_o !== 32'h0 || bus_sel_o !== 4'h0) begin
                    miscompares++;
                    $display("[TB] FAIL rst_mid: got ctrl %b addr %h wdata %h rdata %h sel %h, expected 0000 and zeros",
                             {bus_cyc_o, bus_stb_o, bus_we_o, err_o}, bus_addr_o, bus_wdata_o, rdata_o, bus_sel_o);
                end
            end
            if (c == 4) begin
                vectors++;
                if (bus_cyc_o !== 1'b0 || rdata_o !== 32'h0 || stallreq_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rst_late_ack: got cyc %b rdata %h stall %b, expected 0 00000000 0",
                             bus_cyc_o, rdata_o, stallreq_o);
                end
            end
            if (c == 5) begin
                vectors++;
                if (stallreq_o !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL rst_idle: got stall %b, expected 1", stallreq_o);
                end
                idle_inputs();
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_mem_stall();
        test_flush_busy();
        test_idle_flush();
        test_hold_flush();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
